vic_arbiter: RTL and testbench

Priority arbiter and CPU handshake sequencer for the VICtor interrupt controller. Takes the 31 captured interrupt lines from the edge/level capture stage, selects the highest-priority unmasked pending source, and presents it to the CPU as a request plus a 5-bit vector address. It then runs the acknowledge / end-of-interrupt handshake and returns a one-cycle clear pulse to the capture stage for the serviced line.

---
 rtl/vic_pkg.sv | 20 ++
 rtl/vic_arbiter_if.sv | 28 ++
 rtl/vic_prio_enc.sv | 30 +++
 rtl/vic_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vic_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vic_pkg.sv
// Shared types and constants for the VICtor arbiter: sizes, FSM state encoding
// and the in-service stack entry.
package vic_pkg;

  localparam int N_IRQ  = 31;
  localparam int PRIO_W = 2;
  localparam int VEC_W  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [VEC_W-1:0]  vec;
  } stk_entry_t;

endpackage

// File: rtl/vic_arbiter_if.sv
// Arbiter bus: capture-stage lines, CPU handshake and status outputs.
// master = capture stage / CPU side, slave = the arbiter.
interface vic_arbiter_if;
  import vic_pkg::*;

  logic                      i_en;
  logic [N_IRQ-1:0]          i_pending;
  logic [N_IRQ-1:0]          i_mask;
  logic [N_IRQ*PRIO_W-1:0]   i_prio;
  logic                      i_ack;
  logic                      i_eoi;
  logic                      o_irq;
  logic [VEC_W-1:0]          o_irq_addr;
  logic [N_IRQ-1:0]          o_clr;
  logic                      o_busy;
  logic [PRIO_W-1:0]         o_level;

  modport master (
    output i_en, i_pending, i_mask, i_prio, i_ack, i_eoi,
    input  o_irq, o_irq_addr, o_clr, o_busy, o_level
  );

  modport slave (
    input  i_en, i_pending, i_mask, i_prio, i_ack, i_eoi,
    output o_irq, o_irq_addr, o_clr, o_busy, o_level
  );

endinterface

// File: rtl/vic_prio_enc.sv
// Combinational priority encoder: reduces the candidate lines to the
// highest-priority one, lowest index winning ties.
module vic_prio_enc
  import vic_pkg::*;
(
  input  logic [N_IRQ-1:0]        cand_i,
  input  logic [N_IRQ*PRIO_W-1:0] prio_i,
  output logic                    valid_o,
  output logic [PRIO_W-1:0]       prio_o,
  output logic [VEC_W-1:0]        idx_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    valid_o = 1'b0;
    prio_o  = '0;
    idx_o   = '0;
    // NOTE: blocking assignments make this an ordered scan; each iteration sees
    // the best-so-far left by the previous one.
    for (int i = 0; i < N_IRQ; i++) begin
      // Strict '>' keeps the earlier (lower) index on equal priority.
      if (cand_i[i] && (!valid_o || prio_i[i*PRIO_W +: PRIO_W] > prio_o)) begin
        valid_o = 1'b1;
        prio_o  = prio_i[i*PRIO_W +: PRIO_W];
        idx_o   = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/vic_arbiter.sv
// VICtor priority arbiter and CPU ack/EOI sequencer with in-service stack.
// Optional feature macro: VIC_NESTING_EN (preemption from SERVICE, 4-deep stack).
module vic_arbiter
  import vic_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  vic_arbiter_if.slave  bus
);

`ifdef VIC_NESTING_EN
  localparam int DEPTH = 4;
  localparam bit NEST  = 1'b1;
`else
  localparam int DEPTH = 1;
  localparam bit NEST  = 1'b0;
`endif
  localparam int SP_W = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic               irq_q, irq_d;
  logic [VEC_W-1:0]   addr_q, addr_d;
  logic [PRIO_W-1:0]  rprio_q, rprio_d;
  logic [N_IRQ-1:0]   clr_q, clr_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [PRIO_W-1:0]  level_q, level_d;
  logic               busy_q, busy_d;
  stk_entry_t         stack_q [DEPTH];

  logic               push;
  stk_entry_t         push_entry;
  stk_entry_t         top_ent, below_ent;
  logic [VEC_W-1:0]   pop_vec, rest_vec;
  logic               ack_take, pop, eligible;

  logic [N_IRQ-1:0]   cand;
  logic               cand_valid;
  logic [PRIO_W-1:0]  cand_prio;
  logic [VEC_W-1:0]   cand_idx;

  assign cand = bus.i_pending & bus.i_mask;

  vic_prio_enc u_enc (
    .cand_i  (cand),
    .prio_i  (bus.i_prio),
    .valid_o (cand_valid),
    .prio_o  (cand_prio),
    .idx_o   (cand_idx)
  );

  // Innermost entry and the one beneath it (what becomes innermost on a pop).
  always_comb begin
    top_ent   = '0;
    below_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(sp_q) == i + 1) top_ent   = stack_q[i];
      if (int'(sp_q) == i + 2) below_ent = stack_q[i];
    end
  end

  assign ack_take   = (state_q == REQ) && bus.i_ack;
  assign pop        = bus.i_eoi && busy_q && !ack_take;
  assign eligible   = bus.i_en && cand_valid && (!busy_q || cand_prio > level_q);
  assign pop_vec    = (sp_q > SP_W'(1)) ? below_ent.vec : '0;
  assign rest_vec   = pop ? pop_vec : (busy_q ? top_ent.vec : '0);
  assign push_entry = '{prio: rprio_q, vec: addr_q};

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    addr_d  = addr_q;
    rprio_d = rprio_q;
    clr_d   = '0;
    sp_d    = sp_q;
    level_d = level_q;
    busy_d  = busy_q;
    push    = 1'b0;

    if (pop) begin
      sp_d    = sp_q - SP_W'(1);
      busy_d  = sp_q > SP_W'(1);
      level_d = (sp_q > SP_W'(1)) ? below_ent.prio : '0;
    end

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          addr_d = pop_vec;
        end else if (eligible) begin
          state_d = REQ;
          irq_d   = 1'b1;
          addr_d  = cand_idx;
          rprio_d = cand_prio;
        end
      end
      REQ: begin
        if (ack_take) begin
          clr_d   = N_IRQ'(1) << addr_q;
          irq_d   = 1'b0;
          state_d = SERVICE;
          if (int'(sp_q) < DEPTH) begin
            push    = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            busy_d  = 1'b1;
            level_d = rprio_q;
          end
        end else if (eligible) begin
          addr_d  = cand_idx;
          rprio_d = cand_prio;
        end else begin
          // Withdrawn or disabled: fall back to showing the serviced vector.
          state_d = IDLE;
          irq_d   = 1'b0;
          addr_d  = rest_vec;
        end
      end
      SERVICE: begin
        if (pop) begin
          state_d = IDLE;
          addr_d  = pop_vec;
        end else if (NEST && eligible) begin
          state_d = REQ;
          irq_d   = 1'b1;
          addr_d  = cand_idx;
          rprio_d = cand_prio;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      addr_q  <= '0;
      rprio_q <= '0;
      clr_q   <= '0;
      sp_q    <= '0;
      level_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      addr_q  <= addr_d;
      rprio_q <= rprio_d;
      clr_q   <= clr_d;
      sp_q    <= sp_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: stack storage is not reset; sp_q alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(sp_q) == i) stack_q[i] <= push_entry;
      end
    end
  end

  assign bus.o_irq      = irq_q;
  assign bus.o_irq_addr = addr_q;
  assign bus.o_clr      = clr_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_level    = level_q;

endmodule

// File: tb/tb_vic_arbiter.sv
// Self-checking bench for vic_arbiter: per-cycle model comparison plus
// directed scenarios with literal expectations (both macro settings).
module tb_vic_arbiter;

`ifdef VIC_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  vic_arbiter_if bus ();

  vic_arbiter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_req;
  logic [4:0]  m_addr;
  int          m_rprio;
  logic [30:0] m_clr;
  int          q_prio [$];
  int          q_vec  [$];

  // Highest level first, then lowest index within that level.
  task automatic winner(output bit v, output int p, output int idx);
    v = 1'b0; p = 0; idx = 0;
    for (int lv = 3; lv >= 0; lv--) begin
      for (int i = 0; i < 31; i++) begin
        if (!v && bus.i_pending[i] && bus.i_mask[i] && int'(bus.i_prio[2*i +: 2]) == lv) begin
          v = 1'b1; p = lv; idx = i;
        end
      end
    end
  endtask

  function automatic logic [4:0] top_vec();
    return (q_vec.size() > 0) ? 5'(q_vec[$]) : 5'd0;
  endfunction

  task automatic model_step();
    bit v, take_ack, pop, elig;
    int wp, wi, lvl;
    if (rst) begin
      m_req = 1'b0; m_addr = '0; m_rprio = 0; m_clr = '0;
      q_prio.delete(); q_vec.delete();
      return;
    end
    winner(v, wp, wi);
    lvl      = (q_prio.size() > 0) ? q_prio[$] : 0;
    elig     = bus.i_en && v && (q_prio.size() == 0 || wp > lvl);
    take_ack = m_req && bus.i_ack;
    pop      = bus.i_eoi && (q_prio.size() > 0) && !take_ack;
    m_clr    = '0;
    if (take_ack) begin
      m_clr = 31'(1) << m_addr;
      q_prio.push_back(m_rprio);
      q_vec.push_back(int'(m_addr));
      m_req = 1'b0;
    end else begin
      if (pop) begin
        void'(q_prio.pop_back());
        void'(q_vec.pop_back());
      end
      if (m_req) begin
        if (elig) begin
          m_addr = 5'(wi); m_rprio = wp;
        end else begin
          m_req = 1'b0; m_addr = top_vec();
        end
      end else if (pop) begin
        m_addr = top_vec();
      end else if (elig && (NEST || q_prio.size() == 0)) begin
        m_req = 1'b1; m_addr = 5'(wi); m_rprio = wp;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("model.irq",   32'(bus.o_irq),      32'(m_req));
    check("model.addr",  32'(bus.o_irq_addr), 32'(m_addr));
    check("model.clr",   32'(bus.o_clr),      32'(m_clr));
    check("model.busy",  32'(bus.o_busy),     32'(q_prio.size() > 0));
    check("model.level", 32'(bus.o_level),    (q_prio.size() > 0) ? 32'(q_prio[$]) : 32'd0);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int i, input int p);
    bus.i_prio[2*i +: 2] = 2'(p);
  endtask

  task automatic pulse_ack();
    bus.i_ack = 1'b1; tick(); bus.i_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.i_eoi = 1'b1; tick(); bus.i_eoi = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_en = 1'b1; bus.i_pending = '0; bus.i_mask = '1; bus.i_prio = '0;
    bus.i_ack = 1'b0; bus.i_eoi = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check("rst.irq",  32'(bus.o_irq), 32'd0);
    check("rst.addr", 32'(bus.o_irq_addr), 32'd0);
    check("rst.clr",  32'(bus.o_clr), 32'd0);
    check("rst.busy", 32'(bus.o_busy), 32'd0);
    check("rst.lvl",  32'(bus.o_level), 32'd0);
    rst = 1'b0;

    // Stray ack and eoi in IDLE with nothing pending are ignored.
    bus.i_ack = 1'b1; bus.i_eoi = 1'b1; tick(); bus.i_ack = 1'b0; bus.i_eoi = 1'b0;
    check("stray.clr",  32'(bus.o_clr), 32'd0);
    check("stray.busy", 32'(bus.o_busy), 32'd0);

    // Basic handshake on line 7, priority 1.
    set_prio(7, 1); bus.i_pending[7] = 1'b1; tick();
    check("basic.irq",  32'(bus.o_irq), 32'd1);
    check("basic.addr", 32'(bus.o_irq_addr), 32'd7);
    pulse_ack(); bus.i_pending = '0;
    check("basic.clr",  32'(bus.o_clr), 32'h0000_0080);
    check("basic.irq0", 32'(bus.o_irq), 32'd0);
    check("basic.busy", 32'(bus.o_busy), 32'd1);
    check("basic.lvl",  32'(bus.o_level), 32'd1);
    tick();
    check("basic.clr1", 32'(bus.o_clr), 32'd0);
    pulse_eoi();
    check("basic.eoi",  32'(bus.o_busy), 32'd0);
    tick();

    // Arbitration: higher priority wins; equal priority goes to lower index.
    set_prio(3, 2); set_prio(20, 3);
    bus.i_pending[3] = 1'b1; bus.i_pending[20] = 1'b1; tick();
    check("arb.hi", 32'(bus.o_irq_addr), 32'd20);
    bus.i_pending = '0; tick();
    check("arb.wd", 32'(bus.o_irq), 32'd0);
    set_prio(9, 2); bus.i_pending[3] = 1'b1; bus.i_pending[9] = 1'b1; tick();
    check("arb.tie", 32'(bus.o_irq_addr), 32'd3);
    bus.i_pending = '0; tick();

    // Pre-ack preemption: line 12 prio 3 overtakes line 5 prio 0.
    set_prio(5, 0); set_prio(12, 3); bus.i_pending[5] = 1'b1; tick();
    check("pre.addr5", 32'(bus.o_irq_addr), 32'd5);
    bus.i_pending[12] = 1'b1; tick();
    check("pre.addr12", 32'(bus.o_irq_addr), 32'd12);
    check("pre.irq",    32'(bus.o_irq), 32'd1);
    pulse_ack(); bus.i_pending[12] = 1'b0;
    check("pre.clr", 32'(bus.o_clr), 32'h0000_1000);
    check("pre.lvl", 32'(bus.o_level), 32'd3);
    tick();
    pulse_eoi();
    check("pre.eoi.busy", 32'(bus.o_busy), 32'd0);
    check("pre.eoi.irq",  32'(bus.o_irq), 32'd0);
    tick();
    check("pre.resume", 32'(bus.o_irq_addr), 32'd5);
    bus.i_pending = '0; tick(); tick();

    // Nesting: service line 4 (prio 1), then line 30 (prio 2) arrives.
    set_prio(4, 1); set_prio(30, 2); bus.i_pending[4] = 1'b1; tick();
    pulse_ack(); bus.i_pending = '0;
    check("nest.lvl1", 32'(bus.o_level), 32'd1);
    bus.i_pending[30] = 1'b1; tick();
    if (NEST) begin
      check("nest.irq",  32'(bus.o_irq), 32'd1);
      check("nest.addr", 32'(bus.o_irq_addr), 32'd30);
      pulse_ack(); bus.i_pending = '0;
      check("nest.clr",  32'(bus.o_clr), 32'h4000_0000);
      check("nest.lvl2", 32'(bus.o_level), 32'd2);
      pulse_eoi();
      check("nest.pop.lvl",  32'(bus.o_level), 32'd1);
      check("nest.pop.addr", 32'(bus.o_irq_addr), 32'd4);
      check("nest.pop.busy", 32'(bus.o_busy), 32'd1);
      tick();
      pulse_eoi();
      check("nest.pop2", 32'(bus.o_busy), 32'd0);
    end else begin
      check("flat.noirq", 32'(bus.o_irq), 32'd0);
      check("flat.addr",  32'(bus.o_irq_addr), 32'd4);
      pulse_eoi();
      check("flat.eoi",   32'(bus.o_busy), 32'd0);
      tick();
      check("flat.irq",   32'(bus.o_irq), 32'd1);
      check("flat.addr2", 32'(bus.o_irq_addr), 32'd30);
      pulse_ack(); bus.i_pending = '0;
      pulse_eoi();
    end
    tick();

    // Withdraw: mask drops while requesting, no clear pulse.
    set_prio(10, 1); bus.i_pending[10] = 1'b1; tick();
    check("wd.irq", 32'(bus.o_irq), 32'd1);
    bus.i_mask[10] = 1'b0; tick();
    check("wd.irq0", 32'(bus.o_irq), 32'd0);
    check("wd.clr",  32'(bus.o_clr), 32'd0);
    tick();
    check("wd.clr1", 32'(bus.o_clr), 32'd0);
    bus.i_mask = '1;

    // Disable while in service keeps the stack; EOI still pops.
    tick();
    pulse_ack(); bus.i_pending = '0;
    bus.i_en = 1'b0; tick(); tick(); tick();
    check("dis.busy", 32'(bus.o_busy), 32'd1);
    pulse_eoi();
    check("dis.eoi",  32'(bus.o_busy), 32'd0);
    bus.i_pending[10] = 1'b1; tick();
    check("dis.noirq", 32'(bus.o_irq), 32'd0);
    bus.i_pending = '0; bus.i_en = 1'b1; tick();

    // Reset while in service.
    bus.i_pending[4] = 1'b1; tick();
    pulse_ack(); bus.i_pending = '0;
    if (NEST) begin
      bus.i_pending[30] = 1'b1; tick();
      pulse_ack(); bus.i_pending = '0;
      check("rst2.lvl", 32'(bus.o_level), 32'd2);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    check("rsts.irq",  32'(bus.o_irq), 32'd0);
    check("rsts.addr", 32'(bus.o_irq_addr), 32'd0);
    check("rsts.clr",  32'(bus.o_clr), 32'd0);
    check("rsts.busy", 32'(bus.o_busy), 32'd0);
    check("rsts.lvl",  32'(bus.o_level), 32'd0);
    tick();

    // Ack and EOI together: ack wins, depth grows by one.
    if (NEST) begin
      bus.i_pending[4] = 1'b1; tick();
      pulse_ack(); bus.i_pending = '0;
      bus.i_pending[30] = 1'b1; tick();
      bus.i_ack = 1'b1; bus.i_eoi = 1'b1; tick();
      bus.i_ack = 1'b0; bus.i_eoi = 1'b0; bus.i_pending = '0;
      check("both.lvl",  32'(bus.o_level), 32'd2);
      check("both.clr",  32'(bus.o_clr), 32'h4000_0000);
      pulse_eoi();
      check("both.pop",  32'(bus.o_level), 32'd1);
      tick();
      pulse_eoi();
    end else begin
      bus.i_pending[7] = 1'b1; tick();
      bus.i_ack = 1'b1; bus.i_eoi = 1'b1; tick();
      bus.i_ack = 1'b0; bus.i_eoi = 1'b0; bus.i_pending = '0;
      check("both.busy", 32'(bus.o_busy), 32'd1);
      check("both.clr",  32'(bus.o_clr), 32'h0000_0080);
      pulse_eoi();
    end
    check("both.end", 32'(bus.o_busy), 32'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
